// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM encoding, mode constants and saturation helper for pe_mac_stream.
package pe_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_ACC  = 1'b1;
    // Clamp a wide signed value into the range of a w-bit signed number
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/pe_adder_tree.sv
// pe_adder_tree: combinational signed reduction of LANES packed W-bit operands, lane 0 in LSBs.
module pe_adder_tree #(
    parameter int LANES = 4,
    parameter int W = 16,
    localparam int OW = W + $clog2(LANES)
) (
    input  logic [LANES*W-1:0]   terms,
    output logic signed [OW-1:0] sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) sum = sum + OW'($signed(terms[i*W +: W]));
    end
endmodule

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: LANES-wide signed dot product plus psum, pass or grouped accumulate, valid/ready with full stall.
// Define PE_MAC_SATURATE_EN for saturating stage-2 adds and the o_sat flag.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int I_X       = 8,
    parameter int I_W       = 8,
    parameter int I_PSUM    = 16,
    parameter int O_PSUM    = 24,
    parameter int LANES     = 4,
    parameter int ACC_LEN_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_w_load,
    input  logic [LANES*I_W-1:0]   i_w,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*I_X-1:0]   i_x,
    input  logic [I_PSUM-1:0]      i_psum,
    input  logic                   i_mode,
    input  logic [ACC_LEN_W-1:0]   i_acc_len,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [O_PSUM-1:0]      o_psum
`ifdef PE_MAC_SATURATE_EN
    , output logic                 o_sat
`endif
);
    localparam int PW = I_X + I_W;
    localparam int DW = PW + $clog2(LANES);

    logic [LANES*I_W-1:0] w_reg;
    logic stall, accept, adv;
    logic [ACC_LEN_W-1:0] cnt, len, len_eff;
    logic mode, mode_eff, first, last;
    logic v1, first1, last1;
    logic [LANES*PW-1:0] prod1;
    logic signed [O_PSUM-1:0] psum1, acc, base, sum;
    logic signed [DW-1:0] dot;
    state_t state, state_nx;
`ifdef PE_MAC_SATURATE_EN
    logic signed [63:0] wide, clip;
    logic sat_acc, sat_now;
`endif

    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;
    assign accept  = i_valid & o_ready;
    assign adv     = v1 & ~stall;

    // Group boundaries are resolved at acceptance so back-to-back groups need no bubble
    always_comb begin
        first    = (cnt == '0);
        mode_eff = first ? i_mode : mode;
        len_eff  = !first ? len : (i_acc_len == '0) ? ACC_LEN_W'(1) : i_acc_len;
        last     = (mode_eff != MODE_ACC) || (cnt + ACC_LEN_W'(1) == len_eff);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            w_reg  <= '0;
            cnt    <= '0;
            len    <= '0;
            mode   <= MODE_PASS;
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            prod1  <= '0;
            psum1  <= '0;
        end else begin
            if (i_w_load) w_reg <= i_w;
            if (!stall) begin
                v1 <= accept;
                if (accept) begin
                    cnt    <= last ? '0 : cnt + ACC_LEN_W'(1);
                    len    <= len_eff;
                    mode   <= mode_eff;
                    first1 <= first;
                    last1  <= last;
                    psum1  <= O_PSUM'($signed(i_psum));
                    for (int i = 0; i < LANES; i++)
                        prod1[i*PW +: PW] <= PW'($signed(i_x[i*I_X +: I_X])) * PW'($signed(w_reg[i*I_W +: I_W]));
                end
            end
        end
    end

    pe_adder_tree #(.LANES(LANES), .W(PW)) u_tree (.terms(prod1), .sum(dot));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = adv ? (last1 ? ST_OUT : ST_ACC) : (state == ST_OUT && i_ready) ? ST_IDLE : state;
    end

    always_comb begin
        base = first1 ? psum1 : acc;
`ifdef PE_MAC_SATURATE_EN
        wide    = 64'(base) + 64'(dot);
        clip    = sat_clip(wide, O_PSUM);
        sum     = O_PSUM'(clip);
        sat_now = (clip != wide) || (!first1 && sat_acc);
`else
        sum = base + O_PSUM'(dot);
`endif
        o_valid = (state == ST_OUT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc    <= '0;
            o_psum <= '0;
`ifdef PE_MAC_SATURATE_EN
            sat_acc <= 1'b0;
            o_sat   <= 1'b0;
`endif
        end else if (adv) begin
            if (last1) o_psum <= sum;
            else acc <= sum;
`ifdef PE_MAC_SATURATE_EN
            if (last1) o_sat <= sat_now;
            else sat_acc <= sat_now;
`endif
        end
    end
endmodule

// File: tb/tb_pe_mac_stream.sv
// tb_pe_mac_stream: directed self-checking bench for pe_mac_stream (LANES=4, O_PSUM=18).
module tb_pe_mac_stream;
    import pe_pkg::*;
    localparam int O_PSUM = 18;

    logic i_clk, i_rst_n, i_w_load, i_valid, o_ready, i_mode, o_valid, i_ready;
    logic [31:0] i_w, i_x;
    logic [15:0] i_psum;
    logic [7:0] i_acc_len;
    logic [O_PSUM-1:0] o_psum;
`ifdef PE_MAC_SATURATE_EN
    logic o_sat;
`endif

    int checks = 0;
    int errors = 0;
    int idx, outn;
    logic took, sent;

    pe_mac_stream #(.O_PSUM(O_PSUM)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_w_load(i_w_load), .i_w(i_w),
        .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x), .i_psum(i_psum),
        .i_mode(i_mode), .i_acc_len(i_acc_len), .o_valid(o_valid),
        .i_ready(i_ready), .o_psum(o_psum)
`ifdef PE_MAC_SATURATE_EN
        , .o_sat(o_sat)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic int res();
        return int'($signed(o_psum));
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_w(input logic [31:0] w);
        i_w_load = 1'b1;
        i_w = w;
        step();
        i_w_load = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic [31:0] x, input int p, input int exp);
        i_mode = MODE_PASS;
        i_valid = 1'b1;
        i_x = x;
        i_psum = 16'(p);
        step();
        i_valid = 1'b0;
        check({tag, "_lat1"}, int'(o_valid), 0);
        step();
        check({tag, "_v"}, int'(o_valid), 1);
        check(tag, res(), exp);
        step();
        check({tag, "_gone"}, int'(o_valid), 0);
    endtask

    task automatic wait_out(input string tag, input int exp, input int exp_sat);
        int n = 0;
        while (!o_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_v"}, int'(o_valid), 1);
        check(tag, res(), exp);
`ifdef PE_MAC_SATURATE_EN
        check({tag, "_sat"}, int'(o_sat), exp_sat);
`else
        if (exp_sat != 0 && exp_sat != 1) check({tag, "_satarg"}, exp_sat, 0);
`endif
        step();
        check({tag, "_single"}, int'(o_valid), 0);
    endtask

    // First beat carries the real psum; later beats carry 99 and flip mode/len, both of which must be ignored
    task automatic send_group(input string tag, input int glen, input int n, input logic [31:0] x,
                              input int pfirst, input int exp, input int exp_sat);
        i_mode = MODE_ACC;
        i_acc_len = 8'(glen);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_x = x;
            i_psum = 16'((k == 0) ? pfirst : 99);
            if (k > 0) begin
                i_mode = MODE_PASS;
                i_acc_len = 8'd1;
            end
            step();
            check({tag, "_early"}, int'(o_valid), 0);
        end
        i_valid = 1'b0;
        wait_out(tag, exp, exp_sat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0;
        i_w_load = 1'b0;
        i_w = '0;
        i_valid = 1'b0;
        i_x = '0;
        i_psum = '0;
        i_mode = MODE_PASS;
        i_acc_len = '0;
        i_ready = 1'b1;
        repeat (3) step();
        i_rst_n = 1'b1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_psum", res(), 0);
        check("rst_ready", int'(o_ready), 1);

        load_w(pk(1, 1, 1, 1));
        run_pass("pass", pk(1, 2, 3, 4), 10, 20);
        run_pass("pass_neg", pk(-1, -2, -3, -4), -10, -20);

        for (int c = 0; c < 10; c++) begin
            i_valid = (c < 8);
            i_x = pk(c, c, c, c);
            i_psum = 16'(c);
            step();
            if (c >= 1 && c <= 8) begin
                check("b2b_v", int'(o_valid), 1);
                check("b2b", res(), 5 * (c - 1));
            end
        end
        check("b2b_end", int'(o_valid), 0);

        load_w(pk(2, 0, 0, 0));
        send_group("acc3", 3, 3, pk(5, 1, 1, 1), 7, 37, 0);
        send_group("len1", 1, 1, pk(4, 1, 1, 1), 3, 11, 0);
        send_group("len0", 0, 1, pk(4, 1, 1, 1), 1, 9, 0);

        i_mode = MODE_PASS;
        idx = 0;
        outn = 0;
        for (int cyc = 0; cyc < 30 && outn < 6; cyc++) begin
            i_valid = (idx < 6);
            i_x = pk(idx, 0, 0, 0);
            i_psum = 16'(100 + idx);
            i_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            took = i_valid && o_ready;
            sent = o_valid && i_ready;
            if (o_valid && !i_ready) begin
                check("stall_rdy", int'(o_ready), 0);
                check("stall_hold", res(), 100 + 3 * outn);
            end
            if (sent) begin
                check("stall_ord", res(), 100 + 3 * outn);
                outn++;
            end
            step();
            if (took) idx++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stall_cnt", outn, 6);
        step();
        check("stall_dup", int'(o_valid), 0);

        load_w(pk(1, 1, 1, 1));
        i_valid = 1'b1;
        i_x = pk(1, 1, 1, 1);
        i_psum = 16'd50;
        i_w_load = 1'b1;
        i_w = pk(3, 3, 3, 3);
        step();
        i_w_load = 1'b0;
        step();
        i_valid = 1'b0;
        check("wswap_old", res(), 54);
        step();
        check("wswap_new_v", int'(o_valid), 1);
        check("wswap_new", res(), 62);
        step();

        load_w(pk(-128, -128, -128, -128));
        run_pass("ext1", pk(-128, -128, -128, -128), 0, 65536);
`ifdef PE_MAC_SATURATE_EN
        send_group("ext4", 4, 4, pk(-128, -128, -128, -128), 0, 131071, 1);
`else
        send_group("ext4", 4, 4, pk(-128, -128, -128, -128), 0, 0, 0);
`endif

        load_w(pk(1, 1, 1, 1));
        i_mode = MODE_ACC;
        i_acc_len = 8'd5;
        i_valid = 1'b1;
        i_x = pk(1, 1, 1, 1);
        i_psum = 16'd5;
        repeat (2) step();
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check("rstmid_valid", int'(o_valid), 0);
        step();
        check("rstmid_valid2", int'(o_valid), 0);
        run_pass("rst_w0", pk(1, 1, 1, 1), 7, 7);
        load_w(pk(1, 1, 1, 1));
        send_group("post_rst", 2, 2, pk(1, 1, 1, 1), 1, 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_mac_stream.md
Name: pe_mac_stream

Overview:
- Next-generation processing element for the convolution datapath.
- Computes a LANES-wide signed dot product of a streamed activation vector against a weight-stationary register, then adds an incoming partial sum.
- Runs either per-beat (pass mode) or accumulates over a programmable number of beats before emitting (accumulate mode).
- Uses a valid/ready stream interface with full-pipeline stall; sits between the line buffer and the psum chain / output writer.

Parameters:
- I_X, 8, signed activation width per lane
- I_W, 8, signed weight width per lane
- I_PSUM, 16, signed incoming partial-sum width
- O_PSUM, 24, signed output partial-sum width; must be ≥ I_PSUM and ≥ I_X+I_W+$clog2(LANES)
- LANES, 4, number of parallel multiply lanes (≥1)
- ACC_LEN_W, 8, width of accumulate-length field

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_w_load  in  1  load weight register from i_w this cycle
- i_w  in  LANES*I_W  packed weights, lane 0 in LSBs
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- i_x  in  LANES*I_X  packed activations, lane 0 in LSBs
- i_psum  in  I_PSUM  incoming partial sum (signed)
- i_mode  in  1  0 = pass, 1 = accumulate
- i_acc_len  in  ACC_LEN_W  beats per accumulation group
- o_valid  out  1  output valid
- i_ready  in  1  downstream ready
- o_psum  out  O_PSUM  result (signed)

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset state: all pipeline valids, weight register, accumulator, beat counter and o_psum clear to 0; o_valid=0. A reset mid-group or mid-stall discards all in-flight data.
- Handshakes:
  - Stall = o_valid & ~i_ready; o_ready = ~stall.
  - Input beat accepted when i_valid & o_ready.
  - Output transfers when o_valid & i_ready.
  - On stall, every stage holds.
- Weights:
  - Weight register updates on i_w_load regardless of stall.
  - A beat accepted in the same cycle as i_w_load uses the OLD weights; new weights apply from the next accepted beat.
  - Weight loads mid-group are legal.
- Stage 1 (registered):
  - LANES signed products, each I_X+I_W bits.
  - i_psum sign-extended and registered alongside.
  - Group-start flag, mode and length travel with the beat.
- Stage 2:
  - Signed adder tree sums the products (width I_X+I_W+$clog2(LANES)), then sign-extends to O_PSUM.
- Pass mode:
  - o_psum = psum + dot, o_valid asserted 2 cycles after acceptance (no stall).
  - Throughput 1 beat/cycle.
- Accumulate mode, FSM ST_IDLE → ST_ACC → ST_OUT:
  - ST_IDLE: the first accepted beat latches i_mode and i_acc_len (0 treated as 1); acc = psum + dot.
  - ST_ACC: each further beat does acc += dot; i_psum of non-first beats is ignored.
  - When the beat count reaches the length, result goes to o_psum with o_valid → ST_OUT.
  - ST_OUT: when the output transfers, return to ST_IDLE. A new group's first beat may already be in stage 1 (back-to-back groups, no bubble).
  - i_mode / i_acc_len changes mid-group are ignored until the next group start.
  - A length-1 accumulate group is equivalent to pass mode.
- Arithmetic: two's-complement wrap at O_PSUM bits (default build).

Optional Feature:
- Macro: PE_MAC_SATURATE_EN.
- When defined:
  - Every stage-2 add saturates to [-2^(O_PSUM-1), 2^(O_PSUM-1)-1].
  - Extra output port o_sat (1 bit) is high with o_valid if any add in that result saturated; o_sat resets to 0.
  - Saturation is sticky across an accumulation group.
- When undefined: wrap arithmetic and no o_sat port.

Decomposition:
- Shared package pe_pkg holds:
  - FSM state encoding (ST_IDLE, ST_ACC, ST_OUT)
  - mode constants MODE_PASS / MODE_ACC
  - sat/wrap helper function
- One natural sub-module: pe_adder_tree (parametrised LANES, input width; combinational signed reduction), instantiated in stage 2.

Test Plan:
- Pass, LANES=4: w={1,1,1,1}, x={1,2,3,4}, psum=10 → o_psum=20 with o_valid exactly 2 cycles after acceptance; 8 back-to-back beats → 8 consecutive outputs.
- Accumulate: acc_len=3, w={2,0,0,0}, x0=5 on each beat, psum=7 on the first beat (psum=99 on later beats, ignored) → single output 37, no intermediate o_valid.
- Stall: hold i_ready=0 for 4 cycles with o_valid high → o_psum stable, o_ready=0, no beat lost or duplicated; release → stream resumes in order.
- Weight swap: accept x={1,1,1,1} with i_w_load and w={3,3,3,3} in the same cycle, old w={1,1,1,1} → result psum+4; next beat → psum+12.
- Extremes, O_PSUM=18: all lanes x=-128, w=-128, psum=0 → 65536 (must not saturate). Then a 4-beat group → wraps to 0 in the default build; saturates to 131071 with o_sat=1 under PE_MAC_SATURATE_EN.
- Reset mid-group (after 2 of 5 beats) → o_valid=0 next cycle; weights=0; the next group computes from a clean accumulator.
